// File: rtl/key_step_conditioner_if.sv
// rtl/key_step_conditioner_if.sv - key input and step/level/count outputs of key_step_conditioner
interface key_step_conditioner_if;
  logic       key_n;
  logic       step;
  logic       pressed;
  logic [7:0] press_count;

  modport master (output key_n, input step, input pressed, input press_count);
  modport slave  (input key_n, output step, output pressed, output press_count);
endinterface

// File: rtl/key_step_conditioner.sv
// rtl/key_step_conditioner.sv - debounced one-cycle step pulse, level and step count from an active-low key
// Defining KEY_AUTOREPEAT_EN adds hold-to-repeat steps after REPEAT_DELAY, then every REPEAT_PERIOD.
module key_step_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input logic                   i_clk,
  input logic                   i_reset,
  key_step_conditioner_if.slave bus
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("key_step_conditioner: parameter out of range");
  end

  typedef enum logic [1:0] {REL, DB_PRESS, HELD, DB_REL} state_t;

  state_t          r_state;
  logic            r_sync1;
  logic            r_sync2;
  logic [DB_W-1:0] r_cnt;
  logic            r_step;
  logic            r_pressed;
  logic [7:0]      r_count;

`ifdef KEY_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
  localparam logic [REP_W-1:0] REP_ONE         = REP_W'(1);

  logic [REP_W-1:0] r_rep;
  logic             r_period_mode;
  logic [REP_W-1:0] w_rep_last;

  assign w_rep_last = r_period_mode ? REP_PERIOD_LAST : REP_DELAY_LAST;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= REL;
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_cnt     <= '0;
      r_step    <= 1'b0;
      r_pressed <= 1'b0;
      r_count   <= 8'd0;
`ifdef KEY_AUTOREPEAT_EN
      r_rep         <= '0;
      r_period_mode <= 1'b0;
`endif
    end else begin
      r_sync1 <= bus.key_n;
      r_sync2 <= r_sync1;
      r_step  <= 1'b0;
      case (r_state)
        REL: begin
          if (!r_sync2) begin
            r_state <= DB_PRESS;
            r_cnt   <= DB_ONE;
          end
        end
        DB_PRESS: begin
          if (r_sync2) begin
            r_state <= REL;
            r_cnt   <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_state   <= HELD;
            r_step    <= 1'b1;
            r_pressed <= 1'b1;
            r_count   <= r_count + 8'd1;
`ifdef KEY_AUTOREPEAT_EN
            r_rep         <= '0;
            r_period_mode <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + DB_ONE;
          end
        end
        HELD: begin
          if (r_sync2) begin
            r_state <= DB_REL;
            r_cnt   <= DB_ONE;
          end else begin
`ifdef KEY_AUTOREPEAT_EN
            // Repeat timer only advances while the key is steadily held.
            if (r_rep == w_rep_last) begin
              r_step        <= 1'b1;
              r_count       <= r_count + 8'd1;
              r_rep         <= '0;
              r_period_mode <= 1'b1;
            end else begin
              r_rep <= r_rep + REP_ONE;
            end
`endif
          end
        end
        DB_REL: begin
          if (!r_sync2) begin
            r_state <= HELD;
          end else if (r_cnt == DB_LAST) begin
            r_state   <= REL;
            r_pressed <= 1'b0;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + DB_ONE;
          end
        end
        default: r_state <= REL;
      endcase
    end
  end

  assign bus.step        = r_step;
  assign bus.pressed     = r_pressed;
  assign bus.press_count = r_count;

endmodule

// File: tb/tb_key_step_conditioner.sv
// tb/tb_key_step_conditioner.sv - randomized and directed checks of key_step_conditioner against a run-length model
module tb_key_step_conditioner;

  localparam int D      = 4;
  localparam int DELAY  = 10;
  localparam int PERIOD = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  key_step_conditioner_if bus ();

  key_step_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (DELAY),
    .REPEAT_PERIOD  (PERIOD)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ecount = 0;

  // Model: two-sample delay line, then a run counter of samples that disagree with the debounced level.
  bit m_s1, m_s2, m_level, m_step;
  int m_run, m_h, m_lim, m_count;

  int step_edges[$];
  int rises, highs, fall_edge;
  bit prev_step, prev_pressed;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d edge=%0d", name, act, exp, ecount);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b0; m_step = 1'b0;
    m_run = 0; m_h = 0; m_lim = DELAY; m_count = 0;
  endtask

  task automatic model_edge(input bit k);
    bit p;
    p = !m_s2;
    m_s2 = m_s1;
    m_s1 = k;
    m_step = 1'b0;
    if (p != m_level) begin
      m_run++;
      if (m_run == D) begin
        m_level = p;
        m_run = 0;
        if (p) begin
          m_step = 1'b1;
          m_count = (m_count + 1) % 256;
          m_h = 0;
          m_lim = DELAY;
        end
      end
    end else begin
`ifdef KEY_AUTOREPEAT_EN
      if (m_level && m_run == 0) begin
        m_h++;
        if (m_h == m_lim) begin
          m_step = 1'b1;
          m_count = (m_count + 1) % 256;
          m_h = 0;
          m_lim = PERIOD;
        end
      end
`endif
      m_run = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    ecount++;
    if (rst) model_reset();
    else model_edge(bus.key_n);
    chk("step", int'(bus.step), int'(m_step));
    chk("pressed", int'(bus.pressed), int'(m_level));
    chk("press_count", int'(bus.press_count), m_count);
    if (bus.step) begin
      step_edges.push_back(ecount);
      highs++;
      if (!prev_step) rises++;
    end
    if (!bus.pressed && prev_pressed) fall_edge = ecount;
    prev_step = bus.step;
    prev_pressed = bus.pressed;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic int first_step();
    return (step_edges.size() > 0) ? step_edges[0] : -1;
  endfunction

  initial begin
    int t0;
    int exp_edges[$];
    bus.key_n = 1'b1;
    model_reset();
    run(2);
    rst = 1'b0;
    chk("reset_step", int'(bus.step), 0);
    chk("reset_pressed", int'(bus.pressed), 0);
    chk("reset_count", int'(bus.press_count), 0);
    run(3);

    // Clean press: step exactly at edge 5 relative to the first low sample.
    step_edges.delete();
    bus.key_n = 1'b0;
    t0 = ecount + 1;
    run(12);
    chk("clean_nsteps", step_edges.size(), 1);
    chk("clean_step_edge", first_step() - t0, 5);
    chk("clean_pressed", int'(bus.pressed), 1);
    chk("clean_count", int'(bus.press_count), 1);
    bus.key_n = 1'b1;
    run(10);
    chk("clean_released", int'(bus.pressed), 0);

    // Press bounce 0,1,0,1 then held low.
    step_edges.delete();
    for (int i = 0; i < 4; i++) begin
      bus.key_n = i[0];
      cycle();
    end
    bus.key_n = 1'b0;
    t0 = ecount + 1;
    run(12);
    chk("bounce_nsteps", step_edges.size(), 1);
    chk("bounce_step_edge", first_step() - t0, 5);
    chk("bounce_count", int'(bus.press_count), 2);

    // Release glitch of two cycles while held.
    step_edges.delete();
    bus.key_n = 1'b1;
    run(2);
    bus.key_n = 1'b0;
    run(4);
    chk("glitch_pressed", int'(bus.pressed), 1);
    chk("glitch_nsteps", step_edges.size(), 0);
    fall_edge = -1;
    bus.key_n = 1'b1;
    t0 = ecount + 1;
    run(10);
    chk("release_fall_edge", fall_edge - t0, 5);

    // Random bouncy key against the model.
    for (int i = 0; i < 300; i++) begin
      bus.key_n = 1'($urandom_range(0, 1));
      run(int'($urandom_range(1, 8)));
    end
    bus.key_n = 1'b1;
    run(10);

    // Reset during press debounce with the key held through reset release.
    bus.key_n = 1'b0;
    run(4);
    rst = 1'b1;
    #1;
    chk("rst_mid_step", int'(bus.step), 0);
    chk("rst_mid_pressed", int'(bus.pressed), 0);
    chk("rst_mid_count", int'(bus.press_count), 0);
    run(2);
    rst = 1'b0;
    step_edges.delete();
    t0 = ecount;
    run(12);
    chk("rst_after_step_edge", first_step() - t0, D + 2);
    bus.key_n = 1'b1;
    run(10);

    // Long hold: one step, or the autorepeat train.
    step_edges.delete();
    exp_edges.delete();
    bus.key_n = 1'b0;
    t0 = ecount + 1;
    run(36);
`ifdef KEY_AUTOREPEAT_EN
    exp_edges = '{5, 15, 18, 21, 24, 27, 30, 33};
`else
    exp_edges = '{5};
`endif
    chk("hold_nsteps", step_edges.size(), exp_edges.size());
    for (int i = 0; i < exp_edges.size(); i++)
      chk("hold_step_edge", (i < step_edges.size()) ? step_edges[i] - t0 : -1, exp_edges[i]);
    bus.key_n = 1'b1;
    run(10);

    // 256 clean presses wrap the count back to zero.
    rst = 1'b1;
    #1;
    model_reset();
    run(1);
    rst = 1'b0;
    rises = 0;
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      bus.key_n = 1'b0;
      run(8);
      bus.key_n = 1'b1;
      run(8);
    end
    run(4);
    chk("wrap_count", int'(bus.press_count), 0);
    chk("wrap_rises", rises, 256);
    chk("wrap_high_cycles", highs, 256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_step_conditioner.md
# key_step_conditioner

Conditions one raw active-low push button into a clean, debounced, single-cycle step pulse plus a debounced level. It sits directly upstream of the add/sub accumulator. It replaces the practice of clocking the accumulator from an inverted KEY: the board clock runs everything, and `step` becomes the accumulator's one-cycle update enable. It also keeps an 8-bit count of accepted steps for display and debug.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz); must be ≥ 2.
- `REPEAT_DELAY`, default 25000000: cycles in HELD before the first auto-repeat step (autorepeat build only).
- `REPEAT_PERIOD`, default 5000000: cycles between subsequent auto-repeat steps (autorepeat build only).
- `clk` in 1: single clock; all state is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `key_n` in 1: raw button; 0 = pressed; asynchronous and bouncy.
- `step` out 1: registered, one-cycle pulse per accepted press (and per repeat).
- `pressed` out 1: registered debounced level; 1 = held.
- `press_count` out 8: registered count of `step` pulses; wraps.

## Operation
- **Synchronizer:** two flops on `key_n`, giving `s`. Both flops reset to 1 (released).
- **Debounce counter:** width `$clog2(DEBOUNCE_CYCLES)`. **Repeat counter:** width `$clog2(max(REPEAT_DELAY, REPEAT_PERIOD))`.
- **FSM states:** REL, DB_PRESS, HELD, DB_REL. Reset state is REL.
- **REL:** `s`=0 → DB_PRESS, cnt=1. Otherwise stay.
- **DB_PRESS:**
  - `s`=1 (bounce) → REL, cnt=0, no pulse.
  - `s`=0 and cnt==DEBOUNCE_CYCLES-1 → HELD. Same edge: `step`←1, `pressed`←1, `press_count`←+1, repeat counter←0.
  - Otherwise cnt++.
- **HELD:** `s`=1 → DB_REL, cnt=1. Otherwise stay; repeat logic runs (see Configuration).
- **DB_REL:**
  - `s`=0 (bounce) → HELD. Repeat counter keeps its value and resumes counting.
  - `s`=1 and cnt==DEBOUNCE_CYCLES-1 → REL, `pressed`←0.
  - Otherwise cnt++.
- **Pulse width:** `step` is 1 for exactly one cycle per event. It is never asserted on release.
- **Counter wrap:** `press_count` wraps 255→0.
- **Reset values:** `step`=0, `pressed`=0, `press_count`=0, state=REL, both counters 0, sync flops=1.
- **Reset mid-operation:** asserting `reset` clears everything immediately, including a `step` in flight. If the button is held through reset release, it is treated as a fresh press and accepted after full debounce.

## Timing
- **Press latency:** edge k first samples `key_n`=0 and `key_n` stays low. `s`=0 after edge k+1, DB_PRESS is entered at edge k+2, and `step`/`pressed` rise after edge k+1+DEBOUNCE_CYCLES. `step` falls after edge k+2+DEBOUNCE_CYCLES.
- **Release latency:** symmetric to press latency. `pressed` falls DEBOUNCE_CYCLES+1 edges after the first edge sampling `key_n`=1.
- **Bounce rejection:** any reversal of `s` inside a debounce window restarts acceptance from zero. No output changes.
- **No combinational path:** there is no combinational path from `key_n` to any output.

## Configuration
- **Macro:** `KEY_AUTOREPEAT_EN`.
- **Defined:**
  - While in HELD, the repeat counter increments each cycle.
  - When it reaches REPEAT_DELAY-1 (first repeat) or REPEAT_PERIOD-1 (later repeats): `step`←1, `press_count`←+1, repeat counter←0, and mode switches to period.
  - Mode returns to delay on entry to HELD from DB_PRESS.
  - The counter is frozen in DB_PRESS, DB_REL and REL.
- **Undefined:**
  - The repeat counter and its parameters' logic are removed.
  - Exactly one `step` is produced per debounced press, regardless of hold time.

## Test plan
- **Clean press:** DEBOUNCE_CYCLES=4, `key_n` low sampled at edge 0 and held. → `step`=1 only between edges 5 and 6; `pressed`=1 from edge 5; `press_count`=1.
- **Bounce:** DEBOUNCE_CYCLES=4, `key_n` pattern 0,1,0,1,0 (one cycle each), then held 0. → no `step` during bounce; a single `step` 5 edges after the final low is first sampled; `press_count`=1.
- **Release bounce:** a short high glitch (<4 cycles) while HELD. → `pressed` stays 1 and there is no extra `step`. A clean release then drops `pressed` 5 edges after the first high sample.
- **Wrap:** 256 clean press/release pairs. → `press_count` reads 0; exactly 256 single-cycle `step` pulses.
- **Reset mid-debounce:** `reset` pulsed during DB_PRESS with the button held. → all outputs 0 immediately. After release of `reset`, `step` arrives DEBOUNCE_CYCLES+2 edges later.
- **Autorepeat (`KEY_AUTOREPEAT_EN`):** DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, button held for 30 cycles. → `step` at acceptance, then 10 cycles later, then every 3 cycles.
